// File: rtl/rate_pkg.sv
// rtl/rate_pkg.sv - rate encodings, FSM states and half-period lookup for rate_sched
package rate_pkg;

  typedef enum logic [1:0] {
    MODE_1HZ   = 2'd0,
    MODE_2HZ   = 2'd1,
    MODE_10HZ  = 2'd2,
    MODE_100HZ = 2'd3
  } mode_e;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Half-periods live as parameters of the instance, so they are passed in.
  function automatic int unsigned half_period(input logic [1:0] m,
                                              input int unsigned h0,
                                              input int unsigned h1,
                                              input int unsigned h2,
                                              input int unsigned h3);
    case (m)
      MODE_1HZ:  return h0;
      MODE_2HZ:  return h1;
      MODE_10HZ: return h2;
      default:   return h3;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - 2-flop synchroniser plus stability counter for board switches
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned W          = 2,
  parameter int unsigned CNT_W      = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sw_stable_o
);

  // sw_stable is loaded on the same edge the count would reach DEB_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'((DEB_CYCLES > 1) ? DEB_CYCLES - 2 : 0);

  logic [W-1:0]     meta_q, sync_q, prev_q, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q != stable_q && sync_q == prev_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      meta_q   <= sw_i;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sw_stable_o = stable_q;

endmodule

// File: rtl/rate_sched.sv
// rtl/rate_sched.sv - slow-clock divider whose rate changes only on a falling clk_Hz edge
module rate_sched
  import rate_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned H0         = 25000000,
  parameter int unsigned H1         = 12500000,
  parameter int unsigned H2         = 2500000,
  parameter int unsigned H3         = 250000,
  parameter int unsigned CNT_W      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] SW,
  output logic       clk_Hz,
  output logic       tick,
  output logic [1:0] mode,
  output logic       pending
);

  logic [1:0]       sw_stable;
  logic [CNT_W-1:0] cnt_q, cnt_d, hk_last;
  logic             clk_hz_q, clk_hz_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_q, mode_d;
  logic [0:0]       state_q, state_d;
  logic             wrap, apply;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .W         (2),
    .CNT_W     (CNT_W)
  ) u_sw_debounce (
    .clk        (clk),
    .reset      (reset),
    .sw_i       (SW),
    .sw_stable_o(sw_stable)
  );

  // A new rate is only taken on the wrap that ends a high phase, so the
  // current high phase always completes and the new low phase is full length.
  always_comb begin
    hk_last  = CNT_W'(half_period(mode_q, H0, H1, H2, H3) - 1);
    wrap     = (cnt_q == hk_last);
    apply    = wrap && clk_hz_q && (sw_stable != mode_q);
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    clk_hz_d = wrap ? ~clk_hz_q : clk_hz_q;
    tick_d   = wrap;
    mode_d   = apply ? sw_stable : mode_q;
    state_d  = (sw_stable != mode_d) ? WAIT : RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      clk_hz_q <= 1'b0;
      tick_q   <= 1'b0;
      mode_q   <= MODE_1HZ;
      state_q  <= RUN;
    end else begin
      cnt_q    <= cnt_d;
      clk_hz_q <= clk_hz_d;
      tick_q   <= tick_d;
      mode_q   <= mode_d;
      state_q  <= state_d;
    end
  end

  assign clk_Hz  = clk_hz_q;
  assign tick    = tick_q;
  assign mode    = mode_q;
  assign pending = (state_q == WAIT);

endmodule

// File: tb/tb_rate_sched.sv
// tb/tb_rate_sched.sv - table-driven bench for rate_sched with small debounce and half-periods
module tb_rate_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] SW = 2'd0;
  logic       clk_Hz, tick, pending;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  rate_sched #(
    .DEB_CYCLES(3),
    .H0        (4),
    .H1        (2),
    .H2        (8),
    .H3        (1),
    .CNT_W     (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .SW     (SW),
    .clk_Hz (clk_Hz),
    .tick   (tick),
    .mode   (mode),
    .pending(pending)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [1:0] sw;
    logic       c;
    logic       t;
    logic [1:0] m;
    logic       p;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] sw, input logic c, input logic t,
                     input logic [1:0] m, input logic p);
    vec_t v;
    v.sw = sw; v.c = c; v.t = t; v.m = m; v.p = p;
    tbl.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [1:0] sw, input logic c, input logic t,
                       input logic [1:0] m, input logic p);
    for (int k = 0; k < n; k++) add(sw, c, t, m, p);
  endtask

  task automatic check(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Releases reset mid-cycle; the next rising edge is step 1 of a table.
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      SW = tbl[i].sw;
      @(posedge clk);
      #5;
      check({nm, ".clk_Hz"},  i + 1, {7'd0, clk_Hz},  {7'd0, tbl[i].c});
      check({nm, ".tick"},    i + 1, {7'd0, tick},    {7'd0, tbl[i].t});
      check({nm, ".mode"},    i + 1, {6'd0, mode},    {6'd0, tbl[i].m});
      check({nm, ".pending"}, i + 1, {7'd0, pending}, {7'd0, tbl[i].p});
    end
  endtask

  initial begin
    #15;
    check("reset.clk_Hz",  0, {7'd0, clk_Hz},  8'd0);
    check("reset.tick",    0, {7'd0, tick},    8'd0);
    check("reset.mode",    0, {6'd0, mode},    8'd0);
    check("reset.pending", 0, {7'd0, pending}, 8'd0);

    // mode 0, SW=0: toggle every 4 cycles
    do_reset();
    tbl.delete();
    for (int r = 0; r < 2; r++) begin
      add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
      add_n(3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    end
    run_table("idle");

    // SW 0->1 in a high phase, applied at the following falling edge
    do_reset();
    tbl.delete();
    add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0); add(2'd1, 1'b0, 1'b1, 2'd0, 1'b0);
    add(2'd1, 1'b0, 1'b0, 2'd0, 1'b0);
    add_n(2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1); add(2'd1, 1'b1, 1'b1, 2'd0, 1'b1);
    add_n(3, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(2'd1, 1'b0, 1'b1, 2'd1, 1'b0); add(2'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    add(2'd1, 1'b1, 1'b1, 2'd1, 1'b0); add(2'd1, 1'b1, 1'b0, 2'd1, 1'b0);
    add(2'd1, 1'b0, 1'b1, 2'd1, 1'b0); add(2'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    add(2'd1, 1'b1, 1'b1, 2'd1, 1'b0);
    run_table("to_mode1");

    // 2-cycle glitch on SW must be rejected
    do_reset();
    tbl.delete();
    add_n(2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    add(2'd2, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd2, 1'b1, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    run_table("glitch");

    // request mode 2, withdraw it while pending
    do_reset();
    tbl.delete();
    add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0); add(2'd2, 1'b0, 1'b1, 2'd0, 1'b0);
    add(2'd2, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd2, 1'b0, 1'b0, 2'd0, 1'b1);
    add(2'd0, 1'b0, 1'b0, 2'd0, 1'b1); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b1);
    add_n(3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1); add(2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    run_table("withdraw");

    // mode 3 (H=1): toggle and tick every cycle, return to 0 on a high cycle
    do_reset();
    tbl.delete();
    add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0); add(2'd3, 1'b0, 1'b1, 2'd0, 1'b0);
    add(2'd3, 1'b0, 1'b0, 2'd0, 1'b0);
    add_n(2, 2'd3, 1'b0, 1'b0, 2'd0, 1'b1); add(2'd3, 1'b1, 1'b1, 2'd0, 1'b1);
    add_n(3, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1);
    add(2'd3, 1'b0, 1'b1, 2'd3, 1'b0); add(2'd3, 1'b1, 1'b1, 2'd3, 1'b0);
    add(2'd0, 1'b0, 1'b1, 2'd3, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd3, 1'b0);
    add(2'd0, 1'b0, 1'b1, 2'd3, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd3, 1'b0);
    add(2'd0, 1'b0, 1'b1, 2'd3, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd3, 1'b1);
    add(2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    add_n(3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd0, 1'b1, 1'b1, 2'd0, 1'b0);
    run_table("mode3");

    // SW=1 from reset, then asynchronous reset in a mode-1 high phase
    do_reset();
    tbl.delete();
    add_n(3, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0); add(2'd1, 1'b1, 1'b1, 2'd0, 1'b0);
    add(2'd1, 1'b1, 1'b0, 2'd0, 1'b0);
    add_n(2, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1);
    add(2'd1, 1'b0, 1'b1, 2'd1, 1'b0); add(2'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    add(2'd1, 1'b1, 1'b1, 2'd1, 1'b0);
    run_table("sw1_boot");

    reset = 1'b1;
    #2;
    check("async.clk_Hz",  0, {7'd0, clk_Hz},  8'd0);
    check("async.tick",    0, {7'd0, tick},    8'd0);
    check("async.mode",    0, {6'd0, mode},    8'd0);
    check("async.pending", 0, {7'd0, pending}, 8'd0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    run_table("sw1_rearm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
